// File: rtl/cdb_rr_multilane.sv
// Multi-lane common data bus: NUM_FUS result streams arbitrated round-robin onto
// NUM_CDB registered broadcast lanes. Optional stall statistics via CDB_STALL_STATS_EN.
module cdb_rr_multilane #(
    parameter int XLEN         = 32,
    parameter int RS_TAG_WIDTH = 4,
    parameter int NUM_FUS      = 5,
    parameter int NUM_CDB      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_FUS-1:0]         fu_valid,
    input  logic [XLEN-1:0]            fu_result [NUM_FUS],
    input  logic [RS_TAG_WIDTH-1:0]    fu_tag    [NUM_FUS],
    output logic [NUM_FUS-1:0]         fu_ready,
    output logic [NUM_CDB-1:0]         cdb_valid,
    output logic [XLEN-1:0]            cdb_result [NUM_CDB],
    output logic [RS_TAG_WIDTH-1:0]    cdb_tag    [NUM_CDB],
    output logic [$clog2(NUM_FUS)-1:0] cdb_src    [NUM_CDB]
`ifdef CDB_STALL_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [7:0]                 max_wait
`endif
);

    localparam int SRC_W = $clog2(NUM_FUS);

    generate
        if (NUM_FUS < 2 || NUM_CDB < 1 || NUM_CDB > NUM_FUS) begin : g_bad_cfg
            $error("cdb_rr_multilane: need NUM_FUS >= 2 and 1 <= NUM_CDB <= NUM_FUS");
        end
    endgenerate

    logic [SRC_W-1:0]        rr_ptr;
    logic [SRC_W-1:0]        ptr_next;
    logic [NUM_FUS-1:0]      req;
    logic [NUM_FUS-1:0]      grant;
    logic [NUM_CDB-1:0]      lane_hit;
    logic [XLEN-1:0]         lane_res [NUM_CDB];
    logic [RS_TAG_WIDTH-1:0] lane_tag [NUM_CDB];
    logic [SRC_W-1:0]        lane_src [NUM_CDB];
    logic [SRC_W:0]          scan_sum;
    logic [SRC_W-1:0]        scan_idx;
    logic [SRC_W-1:0]        last_idx;
    int unsigned             n_grant;

    // Flush and reset mask the requests, so every downstream grant is already squashed.
    always_comb begin
        req      = (rst_n && !flush) ? fu_valid : '0;
        grant    = '0;
        lane_hit = '0;
        for (int unsigned j = 0; j < NUM_CDB; j++) begin
            lane_res[j] = '0;
            lane_tag[j] = '0;
            lane_src[j] = '0;
        end
        scan_sum = '0;
        scan_idx = '0;
        last_idx = rr_ptr;
        n_grant  = 0;
        for (int unsigned k = 0; k < NUM_FUS; k++) begin
            scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan_sum >= (SRC_W+1)'(NUM_FUS)) begin
                scan_sum = scan_sum - (SRC_W+1)'(NUM_FUS);
            end
            scan_idx = scan_sum[SRC_W-1:0];
            if (req[scan_idx] && n_grant < NUM_CDB) begin
                grant[scan_idx] = 1'b1;
                for (int unsigned j = 0; j < NUM_CDB; j++) begin
                    if (j == n_grant) begin
                        lane_hit[j] = 1'b1;
                        lane_res[j] = fu_result[scan_idx];
                        lane_tag[j] = fu_tag[scan_idx];
                        lane_src[j] = scan_idx;
                    end
                end
                n_grant  = n_grant + 1;
                last_idx = scan_idx;
            end
        end
        if (flush) begin
            ptr_next = '0;
        end else if (n_grant != 0) begin
            ptr_next = (last_idx == SRC_W'(NUM_FUS - 1)) ? '0 : last_idx + 1'b1;
        end else begin
            ptr_next = rr_ptr;
        end
    end

    assign fu_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            for (int unsigned j = 0; j < NUM_CDB; j++) begin
                cdb_result[j] <= '0;
                cdb_tag[j]    <= '0;
                cdb_src[j]    <= '0;
            end
        end else begin
            rr_ptr    <= ptr_next;
            cdb_valid <= lane_hit;
            // Idle lanes keep their last payload; only valid drops.
            for (int unsigned j = 0; j < NUM_CDB; j++) begin
                if (lane_hit[j]) begin
                    cdb_result[j] <= lane_res[j];
                    cdb_tag[j]    <= lane_tag[j];
                    cdb_src[j]    <= lane_src[j];
                end
            end
        end
    end

`ifdef CDB_STALL_STATS_EN
    logic [7:0]  wait_cnt  [NUM_FUS];
    logic [7:0]  wait_next [NUM_FUS];
    logic [7:0]  wait_peak;
    logic        oversub;
    int unsigned n_req;

    always_comb begin
        n_req     = 0;
        wait_peak = max_wait;
        for (int unsigned i = 0; i < NUM_FUS; i++) begin
            if (fu_valid[i]) begin
                n_req = n_req + 1;
            end
            if (flush || !fu_valid[i] || grant[i]) begin
                wait_next[i] = '0;
            end else if (wait_cnt[i] == '1) begin
                wait_next[i] = wait_cnt[i];
            end else begin
                wait_next[i] = wait_cnt[i] + 8'd1;
            end
            if (wait_next[i] > wait_peak) begin
                wait_peak = wait_next[i];
            end
        end
        oversub = !flush && (n_req > NUM_CDB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            max_wait     <= '0;
            for (int unsigned i = 0; i < NUM_FUS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (oversub && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            max_wait <= wait_peak;
            for (int unsigned i = 0; i < NUM_FUS; i++) begin
                wait_cnt[i] <= wait_next[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_rr_multilane.sv
// Randomized self-checking bench for cdb_rr_multilane against a queue-based
// round-robin reference model; stall statistics checked when CDB_STALL_STATS_EN is defined.
module tb_cdb_rr_multilane;

    localparam int XLEN = 32;
    localparam int TW   = 4;
    localparam int NF   = 5;
    localparam int NC   = 2;
    localparam int SW   = $clog2(NF);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [NF-1:0]   fu_valid = '0;
    logic [XLEN-1:0] fu_result [NF];
    logic [TW-1:0]   fu_tag    [NF];
    logic [NF-1:0]   fu_ready;
    logic [NC-1:0]   cdb_valid;
    logic [XLEN-1:0] cdb_result [NC];
    logic [TW-1:0]   cdb_tag    [NC];
    logic [SW-1:0]   cdb_src    [NC];
`ifdef CDB_STALL_STATS_EN
    logic [31:0]     stall_cycles;
    logic [7:0]      max_wait;
`endif

    cdb_rr_multilane #(
        .XLEN(XLEN), .RS_TAG_WIDTH(TW), .NUM_FUS(NF), .NUM_CDB(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fu_valid(fu_valid), .fu_result(fu_result), .fu_tag(fu_tag),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_tag(cdb_tag), .cdb_src(cdb_src)
`ifdef CDB_STALL_STATS_EN
        , .stall_cycles(stall_cycles), .max_wait(max_wait)
`endif
    );

    always #5 clk = ~clk;

    // FU-side pending results (FU owns them until a transfer) and model lanes
    bit              pv [NF];
    logic [TW-1:0]   pt [NF];
    logic [XLEN-1:0] pr [NF];
    int              ptr;
    bit              lv [NC];
    logic [TW-1:0]   lt [NC];
    logic [XLEN-1:0] lr [NC];
    int              ls [NC];
    int              grant_q [$];
    logic [NF-1:0]   exp_ready;
    logic [NF-1:0]   obs_ready;
    int              stall_m;
    int              wait_m [NF];
    int              maxw_m;
    int              n_tests = 0;
    int              n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requesters ordered by rotational distance from ptr; the first NC win.
    function automatic void arbitrate(input bit fl);
        int order [$];
        grant_q.delete();
        exp_ready = '0;
        if (fl) return;
        for (int i = ptr; i < NF; i++) if (pv[i]) order.push_back(i);
        for (int i = 0; i < ptr; i++) if (pv[i]) order.push_back(i);
        while (order.size() > NC) void'(order.pop_back());
        grant_q = order;
        foreach (grant_q[g]) exp_ready = exp_ready | (NF'(1) << grant_q[g]);
    endfunction

    task automatic check_lanes(input string tag);
        logic [NC-1:0] ev;
        ev = '0;
        for (int j = 0; j < NC; j++) begin
            if (lv[j]) ev = ev | (NC'(1) << j);
            check({tag, "_tag"}, 64'(cdb_tag[j]), 64'(lt[j]));
            check({tag, "_res"}, 64'(cdb_result[j]), 64'(lr[j]));
            check({tag, "_src"}, 64'(cdb_src[j]), 64'(ls[j]));
        end
        check({tag, "_valid"}, 64'(cdb_valid), 64'(ev));
`ifdef CDB_STALL_STATS_EN
        check({tag, "_stall"}, 64'(stall_cycles), 64'(stall_m));
        check({tag, "_maxw"}, 64'(max_wait), 64'(maxw_m));
`endif
    endtask

    task automatic cycle(input bit fl);
        int nv;
        @(negedge clk);
        flush = fl;
        fu_valid = '0;
        for (int i = 0; i < NF; i++) begin
            if (pv[i]) fu_valid = fu_valid | (NF'(1) << i);
            fu_tag[i]    = pt[i];
            fu_result[i] = pr[i];
        end
        #1;
        arbitrate(fl);
        check("fu_ready", 64'(fu_ready), 64'(exp_ready));
        obs_ready = fu_ready;
        nv = 0;
        for (int i = 0; i < NF; i++) begin
            if (pv[i]) nv++;
            if (fl || !pv[i] || ((exp_ready >> i) & 1'b1) == 1'b1) wait_m[i] = 0;
            else if (wait_m[i] < 255) wait_m[i]++;
            if (wait_m[i] > maxw_m) maxw_m = wait_m[i];
        end
        if (!fl && nv > NC) stall_m++;
        @(posedge clk);
        #1;
        for (int j = 0; j < NC; j++) begin
            if (j < grant_q.size()) begin
                lv[j] = 1'b1;
                lt[j] = pt[grant_q[j]];
                lr[j] = pr[grant_q[j]];
                ls[j] = grant_q[j];
            end else begin
                lv[j] = 1'b0;
            end
        end
        if (fl) ptr = 0;
        else if (grant_q.size() > 0) ptr = (grant_q[grant_q.size()-1] + 1) % NF;
        foreach (grant_q[g]) pv[grant_q[g]] = 1'b0;
        check_lanes("lane");
    endtask

    task automatic model_reset();
        ptr = 0;
        stall_m = 0;
        maxw_m = 0;
        for (int j = 0; j < NC; j++) begin
            lv[j] = 1'b0; lt[j] = '0; lr[j] = '0; ls[j] = 0;
        end
        for (int i = 0; i < NF; i++) wait_m[i] = 0;
    endtask

    // Asserted just after an edge so the async clear is visible before the next one.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        check("rst_ready", 64'(fu_ready), 64'(0));
        check_lanes("rst");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < NF; i++) begin
            if (!pv[i] && $urandom_range(0, 99) < pct) begin
                pv[i] = 1'b1;
                pt[i] = TW'($urandom);
                pr[i] = $urandom;
            end
        end
    endtask

    int gcnt [NF];
    int wobs [NF];
    int maxobs;

    initial begin
        for (int i = 0; i < NF; i++) begin
            pv[i] = 1'b0; pt[i] = '0; pr[i] = '0;
            fu_tag[i] = '0; fu_result[i] = '0;
        end
        model_reset();
        do_reset();

        // Directed: first arbitration from pointer 0
        for (int i = 0; i < NF; i++) begin
            pt[i] = TW'(i + 1);
            pr[i] = 32'h100 + 32'(i);
        end
        pv[0] = 1; pv[1] = 1; pv[2] = 1; pv[4] = 1;
        cycle(1'b0);
        check("t1_ready", 64'(obs_ready), 64'(5'b00011));
        check("t1_valid", 64'(cdb_valid), 64'(2'b11));
        check("t1_tag0", 64'(cdb_tag[0]), 64'(1));
        check("t1_src0", 64'(cdb_src[0]), 64'(0));
        check("t1_tag1", 64'(cdb_tag[1]), 64'(2));
        check("t1_src1", 64'(cdb_src[1]), 64'(1));

        // Pointer at 2: FU2 and FU4 win, pointer wraps to 0
        pv[0] = 1; pt[0] = 4'd6; pv[1] = 1; pt[1] = 4'd7;
        cycle(1'b0);
        check("t2_ready", 64'(obs_ready), 64'(5'b10100));
        check("t2_tag0", 64'(cdb_tag[0]), 64'(3));
        check("t2_tag1", 64'(cdb_tag[1]), 64'(5));
        cycle(1'b0);
        check("t2b_ready", 64'(obs_ready), 64'(5'b00011));
        check("t2b_tag0", 64'(cdb_tag[0]), 64'(6));
        check("t2b_tag1", 64'(cdb_tag[1]), 64'(7));

        // Single requester: lane1 idle but keeps its payload
        pv[3] = 1; pt[3] = 4'd9;
        cycle(1'b0);
        check("t3_ready", 64'(obs_ready), 64'(5'b01000));
        check("t3_valid", 64'(cdb_valid), 64'(2'b01));
        check("t3_tag0", 64'(cdb_tag[0]), 64'(9));
        check("t3_tag1_hold", 64'(cdb_tag[1]), 64'(7));

        // Saturated load for 10 cycles from a fresh reset
        do_reset();
        for (int i = 0; i < NF; i++) begin
            gcnt[i] = 0; wobs[i] = 0;
        end
        maxobs = 0;
        for (int c = 0; c < 10; c++) begin
            refill(100);
            cycle(1'b0);
            for (int i = 0; i < NF; i++) begin
                if (((obs_ready >> i) & 1'b1) == 1'b1) begin
                    gcnt[i]++; wobs[i] = 0;
                end else begin
                    wobs[i]++;
                end
                if (wobs[i] > maxobs) maxobs = wobs[i];
            end
        end
        for (int i = 0; i < NF; i++) check("t4_grants", 64'(gcnt[i]), 64'(4));
        check("t4_maxwait", 64'(maxobs), 64'(2));
`ifdef CDB_STALL_STATS_EN
        check("t4_stall_cycles", 64'(stall_cycles), 64'(10));
        check("t4_max_wait", 64'(max_wait), 64'(2));
`endif

        // Flush with everyone requesting, then restart from FU0
        refill(100);
        cycle(1'b1);
        check("t5_ready", 64'(obs_ready), 64'(0));
        check("t5_valid", 64'(cdb_valid), 64'(0));
        cycle(1'b0);
        check("t5_first", 64'(obs_ready), 64'(5'b00011));

        // Random traffic with occasional flushes and mid-burst resets
        for (int c = 0; c < 400; c++) begin
            refill(60);
            if (c == 150 || c == 300) begin
                do_reset();
                refill(100);
                cycle(1'b0);
                check("t6_after_rst", 64'(obs_ready), 64'(5'b00011));
            end else begin
                cycle($urandom_range(0, 19) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
